// File: rtl/add5_arbiter_if.sv
// Operand-request and sum-response bundle shared by the requesters, the
// arbiter and the sum consumer.
interface add5_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_a;
  logic [5*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [4:0]        rsp_s;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_s
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_s
  );
endinterface

// File: rtl/add5_arbiter.sv
// Round-robin arbiter sharing one 5-bit ripple-carry adder between NREQ
// requesters, with a one-entry registered response.
module add5 (
  input  logic [4:0] i_a,
  input  logic [4:0] i_b,
  output logic [4:0] o_s
);
  logic [4:0] w_c;

  assign w_c[0] = 1'b0;
  for (genvar k = 0; k < 5; k++) begin : g_fa
    assign o_s[k] = i_a[k] ^ i_b[k] ^ w_c[k];
    // carry out of bit 4 is intentionally dropped: modulo-32 sum
    if (k < 4) begin : g_cy
      assign w_c[k+1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
    end
  end
endmodule

module add5_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  add5_arbiter_if.slave bus
);
  logic [IDW-1:0]  r_ptr;
  logic            r_vld;
  logic [IDW-1:0]  r_id;
  logic [4:0]      r_s;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic            w_found;
  int              w_idx;
  logic [4:0]      w_a;
  logic [4:0]      w_b;
  logic [4:0]      w_sum;
  logic            w_accept;
  logic            w_xfer;
  logic [IDW-1:0]  w_ptr_nxt;

  // Search upward from the pointer, wrapping at NREQ (not at 2**IDW).
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_a     = '0;
    w_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gid          = IDW'(w_idx);
        w_a            = bus.req_a[w_idx*5 +: 5];
        w_b            = bus.req_b[w_idx*5 +: 5];
      end
    end
  end

  add5 u_add5 (
    .i_a (w_a),
    .i_b (w_b),
    .o_s (w_sum)
  );

  assign w_accept      = ~r_vld | bus.rsp_ready;
  assign bus.req_ready = w_grant & {NREQ{w_accept}};
  assign w_xfer        = |bus.req_ready;
  assign w_ptr_nxt     = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_vld <= 1'b0;
      r_id  <= '0;
      r_s   <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_nxt;
      r_vld <= 1'b1;
      r_id  <= w_gid;
      r_s   <= w_sum;
    end else if (r_vld && bus.rsp_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_vld;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_s     = r_s;
endmodule

// File: tb/tb_add5_arbiter.sv
// Directed bench for add5_arbiter: NREQ=4 instance plus an NREQ=3 instance.
module tb_add5_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  add5_arbiter_if #(.NREQ(4), .IDW(2)) if4 ();
  add5_arbiter_if #(.NREQ(3), .IDW(2)) if3 ();

  add5_arbiter #(.NREQ(4), .IDW(2)) u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
  add5_arbiter #(.NREQ(3), .IDW(2)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));

  // operand tables for the multi-requester tests: sums 11, 21, 10, 4
  logic [4:0] ta [4] = '{5'd7, 5'd12, 5'd25, 5'd30};
  logic [4:0] tb [4] = '{5'd4, 5'd9, 5'd17, 5'd6};
  logic [4:0] ts [4] = '{5'd11, 5'd21, 5'd10, 5'd4};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      if4.req_a[i*5 +: 5] = ta[i];
      if4.req_b[i*5 +: 5] = tb[i];
    end
    for (int i = 0; i < 3; i++) begin
      if3.req_a[i*5 +: 5] = ta[i];
      if3.req_b[i*5 +: 5] = tb[i];
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (if4.rsp_valid !== 1'b0 || if4.rsp_id !== 2'd0 || if4.rsp_s !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b id=%0d s=%0d want v=0 id=0 s=0",
               if4.rsp_valid, if4.rsp_id, if4.rsp_s);
    end
    n_tests++;
    if (if4.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready_idle: got %b want 0000", if4.req_ready);
    end
    n_tests++;
    if (if3.rsp_valid !== 1'b0 || if3.rsp_s !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_rsp3: got v=%b s=%0d want v=0 s=0", if3.rsp_valid, if3.rsp_s);
    end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    if4.req_a[4:0] = 5'd5;
    if4.req_b[4:0] = 5'd9;
    if4.req_valid = 4'b0001;
    if4.rsp_ready = 1'b0;
    #2;
    n_tests++;
    if (if4.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", if4.req_ready);
    end
    step();
    if4.req_valid = 4'b0000;
    n_tests++;
    if (if4.rsp_valid !== 1'b1 || if4.rsp_id !== 2'd0 || if4.rsp_s !== 5'd14) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b id=%0d s=%0d want v=1 id=0 s=14",
               if4.rsp_valid, if4.rsp_id, if4.rsp_s);
    end
    if4.rsp_ready = 1'b1;
    step();
    n_tests++;
    if (if4.rsp_valid !== 1'b0 || if4.rsp_s !== 5'd14) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b s=%0d want v=0 s=14", if4.rsp_valid, if4.rsp_s);
    end
  endtask

  task automatic test_wrap();
    if4.req_a[14:10] = 5'd31;
    if4.req_b[14:10] = 5'd1;
    if4.req_valid = 4'b0100;
    if4.rsp_ready = 1'b1;
    step();
    n_tests++;
    if (if4.rsp_valid !== 1'b1 || if4.rsp_id !== 2'd2 || if4.rsp_s !== 5'd0) begin
      n_fail++;
      $display("FAIL wrap_31p1: got v=%b id=%0d s=%0d want v=1 id=2 s=0",
               if4.rsp_valid, if4.rsp_id, if4.rsp_s);
    end
    if4.req_a[14:10] = 5'd20;
    if4.req_b[14:10] = 5'd15;
    step();
    n_tests++;
    if (if4.rsp_valid !== 1'b1 || if4.rsp_id !== 2'd2 || if4.rsp_s !== 5'd3) begin
      n_fail++;
      $display("FAIL wrap_20p15: got v=%b id=%0d s=%0d want v=1 id=2 s=3",
               if4.rsp_valid, if4.rsp_id, if4.rsp_s);
    end
    if4.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] alt [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    do_reset();
    load_table();
    if4.req_valid = 4'b1111;
    if4.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (if4.rsp_valid !== 1'b1 || if4.rsp_id !== 2'(k % 4) || if4.rsp_s !== ts[k % 4]) begin
        n_fail++;
        $display("FAIL rr_all_%0d: got v=%b id=%0d s=%0d want v=1 id=%0d s=%0d",
                 k, if4.rsp_valid, if4.rsp_id, if4.rsp_s, k % 4, ts[k % 4]);
      end
    end
    // pointer now at 2, so requester 3 wins first
    if4.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (if4.rsp_id !== alt[k] || if4.rsp_s !== ts[alt[k]]) begin
        n_fail++;
        $display("FAIL rr_alt_%0d: got id=%0d s=%0d want id=%0d s=%0d",
                 k, if4.rsp_id, if4.rsp_s, alt[k], ts[alt[k]]);
      end
    end
    if4.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    load_table();
    if4.req_a[9:5] = 5'd3;
    if4.req_b[9:5] = 5'd4;
    if4.req_valid = 4'b0010;
    if4.rsp_ready = 1'b0;
    step();
    if4.req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_tests++;
      if (if4.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready_%0d: got %b want 0000", k, if4.req_ready);
      end
      step();
      n_tests++;
      if (if4.rsp_valid !== 1'b1 || if4.rsp_id !== 2'd1 || if4.rsp_s !== 5'd7) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b id=%0d s=%0d want v=1 id=1 s=7",
                 k, if4.rsp_valid, if4.rsp_id, if4.rsp_s);
      end
    end
    if4.rsp_ready = 1'b1;
    #2;
    n_tests++;
    if (if4.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0100", if4.req_ready);
    end
    step();
    n_tests++;
    if (if4.rsp_valid !== 1'b1 || if4.rsp_id !== 2'd2 || if4.rsp_s !== 5'd10) begin
      n_fail++;
      $display("FAIL bp_release_rsp: got v=%b id=%0d s=%0d want v=1 id=2 s=10",
               if4.rsp_valid, if4.rsp_id, if4.rsp_s);
    end
    if4.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_table();
    if4.req_valid = 4'b0100;
    if4.rsp_ready = 1'b0;
    step();
    if4.req_valid = 4'b0000;
    n_tests++;
    if (if4.rsp_valid !== 1'b1 || if4.rsp_s !== 5'd10) begin
      n_fail++;
      $display("FAIL mid_setup: got v=%b s=%0d want v=1 s=10", if4.rsp_valid, if4.rsp_s);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (if4.rsp_valid !== 1'b0 || if4.rsp_id !== 2'd0 || if4.rsp_s !== 5'd0) begin
      n_fail++;
      $display("FAIL mid_clear: got v=%b id=%0d s=%0d want v=0 id=0 s=0",
               if4.rsp_valid, if4.rsp_id, if4.rsp_s);
    end
    rst_n = 1'b1;
    if4.req_valid = 4'b1111;
    if4.rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (if4.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_grant: got %b want 0001", if4.req_ready);
    end
    step();
    n_tests++;
    if (if4.rsp_id !== 2'd0 || if4.rsp_s !== 5'd11) begin
      n_fail++;
      $display("FAIL mid_first_rsp: got id=%0d s=%0d want id=0 s=11", if4.rsp_id, if4.rsp_s);
    end
    if4.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_nreq3();
    logic [2:0] exp_rdy;
    do_reset();
    load_table();
    if3.req_valid = 3'b111;
    if3.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = 3'b001 << (k % 3);
      #2;
      n_tests++;
      if (if3.req_ready !== exp_rdy || $countones(if3.req_ready) > 1) begin
        n_fail++;
        $display("FAIL n3_ready_%0d: got %b want %b", k, if3.req_ready, exp_rdy);
      end
      step();
      n_tests++;
      if (if3.rsp_id !== 2'(k % 3) || if3.rsp_s !== ts[k % 3]) begin
        n_fail++;
        $display("FAIL n3_rsp_%0d: got id=%0d s=%0d want id=%0d s=%0d",
                 k, if3.rsp_id, if3.rsp_s, k % 3, ts[k % 3]);
      end
    end
    if3.req_valid = 3'b000;
    step();
  endtask

  initial begin
    if4.req_valid = '0;
    if4.req_a     = '0;
    if4.req_b     = '0;
    if4.rsp_ready = 1'b0;
    if3.req_valid = '0;
    if3.req_a     = '0;
    if3.req_b     = '0;
    if3.rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_nreq3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish within 50000 time units");
    $fatal(1);
  end
endmodule
